// File: rtl/key_event_queue.sv
// Key event front end: registers the HID keycode, maps it to crossword codes,
// generates typematic repeat and queues events in a show-ahead FIFO.
module key_event_queue #(
  parameter int unsigned REPEAT_DELAY_CYC  = 25000000,
  parameter int unsigned REPEAT_PERIOD_CYC = 5000000,
  parameter int unsigned DEPTH             = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               keycode,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [7:0]               ev_data,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CW      = PTR_W + 1;
  localparam int unsigned CNT_MAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
                                    REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       kc_q;
  logic [7:0]       held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] term_c;
  logic             map_hit_c;
  logic [7:0]       map_code_c;
  logic             push_c;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             pop_c, full_c, wr_en_c, drop_c;

  // HID usage code to crossword character/command code
  always_comb begin
    map_hit_c  = 1'b1;
    map_code_c = 8'h00;
    if (kc_q >= 8'h04 && kc_q <= 8'h1D) begin
      map_code_c = kc_q + 8'h3D;
    end else begin
      unique case (kc_q)
        8'h2A:   map_code_c = 8'h08;
        8'h2C:   map_code_c = 8'h20;
        8'h28:   map_code_c = 8'h0D;
        8'h4F:   map_code_c = 8'h11;
        8'h50:   map_code_c = 8'h12;
        8'h51:   map_code_c = 8'h13;
        8'h52:   map_code_c = 8'h14;
        default: map_hit_c  = 1'b0;
      endcase
    end
  end

  // Press detection and typematic repeat
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    push_c  = 1'b0;
    term_c  = (state_q == ST_DELAY) ? CNT_W'(REPEAT_DELAY_CYC - 1)
                                    : CNT_W'(REPEAT_PERIOD_CYC - 1);
    unique case (state_q)
      ST_IDLE: begin
        if (map_hit_c) begin
          push_c  = 1'b1;
          held_d  = kc_q;
          cnt_d   = '0;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (!map_hit_c) begin
          held_d  = 8'h00;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (kc_q != held_q) begin
          push_c  = 1'b1;
          held_d  = kc_q;
          cnt_d   = '0;
          state_d = ST_DELAY;
        end else if (cnt_q == term_c) begin
          push_c  = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO control; a pop frees a slot for a push in the same cycle
  always_comb begin
    pop_c    = ev_valid & ev_ready;
    full_c   = (count_q == CW'(DEPTH));
    wr_en_c  = push_c & (~full_c | pop_c);
    drop_c   = push_c & full_c & ~pop_c;
    rd_ptr_d = pop_c   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    if (wr_en_c && !pop_c) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en_c && pop_c) begin
      count_d = count_q - CW'(1);
    end
    ovf_d = ovf_q;
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kc_q     <= 8'h00;
      state_q  <= ST_IDLE;
      held_q   <= 8'h00;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      kc_q     <= keycode;
      state_q  <= state_d;
      held_q   <= held_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only read once written
  always_ff @(posedge clk) begin
    if (reset_n && wr_en_c) begin
      mem_q[wr_ptr_q] <= map_code_c;
    end
  end

  assign ev_valid = (count_q != '0);
  assign ev_data  = mem_q[rd_ptr_q];
  assign ev_count = count_q;
  assign overflow = ovf_q;

endmodule
